// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control encodings: opcodes, immediate selects, ALU ops, writeback selects.
// Used by the decoder, the immediate generator and the EX stage.
package rv_ctrl_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_S     = 3'b001;
   localparam logic [2:0] IMM_B     = 3'b010;
   localparam logic [2:0] IMM_U     = 3'b011;
   localparam logic [2:0] IMM_J     = 3'b100;
   localparam logic [2:0] IMM_SHAMT = 3'b101;
   localparam logic [2:0] IMM_NONE  = 3'b111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src_b;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       branch;
      logic       jump;
      logic       illegal;
      logic [1:0] wb_sel;
   } ctrl_t;

   // SUB/SRA are only selected by bit 30 for register ops; OP-IMM honours it only for shifts.
   function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3, input logic bit30,
                                                 input logic is_reg);
      logic [3:0] op;
      op = ALU_ADD;
      case (funct3)
         3'b000: op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
         3'b001: op = ALU_SLL;
         3'b010: op = ALU_SLT;
         3'b011: op = ALU_SLTU;
         3'b100: op = ALU_XOR;
         3'b101: op = bit30 ? ALU_SRA : ALU_SRL;
         3'b110: op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_decoder.sv
// Pure combinational RV32I decoder: instruction to control bundle, immediate select and
// register indices (indices forced to 0 when the format does not use them).
module rv_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [31:0] inst,
   output ctrl_t       ctrl,
   output logic [2:0]  imm_sel,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       use_rd, use_rs1, use_rs2;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];

   always_comb begin
      ctrl    = '0;
      imm_sel = IMM_NONE;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            imm_sel        = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
            ctrl.alu_op    = alu_from_funct(funct3, inst[30], 1'b0);
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
            use_rd         = 1'b1;
            use_rs1        = 1'b1;
         end
         OPC_LOAD: begin
            imm_sel        = IMM_I;
            ctrl.alu_src_b = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_MEM;
            use_rd         = 1'b1;
            use_rs1        = 1'b1;
         end
         OPC_JALR: begin
            imm_sel        = IMM_I;
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            use_rd         = 1'b1;
            use_rs1        = 1'b1;
         end
         OPC_STORE: begin
            imm_sel        = IMM_S;
            ctrl.alu_src_b = 1'b1;
            ctrl.mem_write = 1'b1;
            use_rs1        = 1'b1;
            use_rs2        = 1'b1;
         end
         OPC_BRANCH: begin
            imm_sel     = IMM_B;
            ctrl.alu_op = ALU_SUB;
            ctrl.branch = 1'b1;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm_sel        = IMM_U;
            ctrl.alu_op    = (opcode == OPC_LUI) ? ALU_PASSB : ALU_ADD;
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
            use_rd         = 1'b1;
         end
         OPC_JAL: begin
            imm_sel        = IMM_J;
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            use_rd         = 1'b1;
         end
         OPC_OP: begin
            ctrl.alu_op    = alu_from_funct(funct3, inst[30], 1'b1);
            ctrl.reg_write = 1'b1;
            use_rd         = 1'b1;
            use_rs1        = 1'b1;
            use_rs2        = 1'b1;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

   assign rd  = use_rd  ? inst[11:7]  : 5'd0;
   assign rs1 = use_rs1 ? inst[19:15] : 5'd0;
   assign rs2 = use_rs2 ? inst[24:20] : 5'd0;

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode-stage controller: decodes IF/ID, detects load-use hazards, applies
// flush > mem_stall > hazard priority and owns the ID/EX control register.
module id_ctrl_stage
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [31:0]      id_inst,
   input  logic [XLEN-1:0]  id_pc,
   input  logic             ex_flush,
   input  logic             mem_stall,
   output logic [2:0]       imm_sel,
   output logic [24:0]      imm_in,
   output logic             stall_if,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [4:0]       ex_rd,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [3:0]       ex_alu_op,
   output logic             ex_alu_src_b,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_reg_write,
   output logic             ex_branch,
   output logic             ex_jump,
   output logic             ex_illegal,
   output logic [1:0]       ex_wb_sel,
   output logic [CNT_W-1:0] bubble_cnt
);

   ctrl_t            dec_ctrl, ctrl_d, ctrl_q;
   logic [4:0]       dec_rd, dec_rs1, dec_rs2;
   logic [4:0]       rd_d, rs1_d, rs2_d, rd_q, rs1_q, rs2_q;
   logic [XLEN-1:0]  pc_d, pc_q;
   logic             valid_d, valid_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             hz, bubble;

   rv_decoder u_decoder (
      .inst    (id_inst),
      .ctrl    (dec_ctrl),
      .imm_sel (imm_sel),
      .rd      (dec_rd),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2)
   );

   assign imm_in = id_inst[31:7];

   // Unused source indices are already 0, and ex_rd==0 is excluded, so they never match.
   assign hz = id_valid & valid_q & ctrl_q.mem_read & (rd_q != 5'd0) &
               ((rd_q == dec_rs1) | (rd_q == dec_rs2));

   assign stall_if = ~ex_flush & (mem_stall | hz);
   assign bubble   = ex_flush | (~mem_stall & hz);

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      pc_d    = pc_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      cnt_d   = cnt_q;
      if (bubble) begin
         // Clearing the whole bundle keeps ex_mem_read low so the hazard clears next cycle.
         valid_d = 1'b0;
         ctrl_d  = '0;
         pc_d    = '0;
         rd_d    = '0;
         rs1_d   = '0;
         rs2_d   = '0;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else if (!mem_stall) begin
         valid_d = id_valid;
         ctrl_d  = dec_ctrl;
         if (dec_ctrl.illegal) begin
            ctrl_d.reg_write = 1'b0;
            ctrl_d.mem_write = 1'b0;
            ctrl_d.mem_read  = 1'b0;
         end
         pc_d  = id_pc;
         rd_d  = dec_rd;
         rs1_d = dec_rs1;
         rs2_d = dec_rs2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pc_q    <= '0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         pc_q    <= pc_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_pc        = pc_q;
   assign ex_rd        = rd_q;
   assign ex_rs1       = rs1_q;
   assign ex_rs2       = rs2_q;
   assign ex_alu_op    = ctrl_q.alu_op;
   assign ex_alu_src_b = ctrl_q.alu_src_b;
   assign ex_mem_read  = ctrl_q.mem_read;
   assign ex_mem_write = ctrl_q.mem_write;
   assign ex_reg_write = ctrl_q.reg_write;
   assign ex_branch    = ctrl_q.branch;
   assign ex_jump      = ctrl_q.jump;
   assign ex_illegal   = ctrl_q.illegal;
   assign ex_wb_sel    = ctrl_q.wb_sel;
   assign bubble_cnt   = cnt_q;

endmodule
